// File: rtl/conv_featuremap_par_if.sv
// Stream/config bundle for conv_featuremap_par: coefficient load port, pixel input, feature-map output.
interface conv_featuremap_par_if #(
  parameter int DATA_WIDTH = 16,
  parameter int CH         = 3
);
  // Handshake: a pixel is taken on any cycle with valid_in && ready (ready is high only while running);
  // cfg_data is taken on cfg_valid while loading; outputs have no backpressure (one-cycle qualifiers).
  logic                     cfg_start;
  logic                     cfg_valid;
  logic [DATA_WIDTH-1:0]    cfg_data;
  logic [CH*DATA_WIDTH-1:0] data_in;
  logic                     valid_in;
  logic [DATA_WIDTH-1:0]    data_out;
  logic                     valid_out;
  logic                     frame_done;
  logic                     ready;

  modport master (
    output cfg_start, cfg_valid, cfg_data, data_in, valid_in,
    input  data_out, valid_out, frame_done, ready
  );

  modport slave (
    input  cfg_start, cfg_valid, cfg_data, data_in, valid_in,
    output data_out, valid_out, frame_done, ready
  );
endinterface

// File: rtl/conv_featuremap_par.sv
// Multi-channel 3x3 valid-padding convolution producing one fixed-point feature map, two-stage pipeline.
// Optional macro CONV_FEATUREMAP_LEAKY_EN applies a 1/8 leaky slope to negative results before saturation.
module conv_featuremap_par #(
  parameter int DATA_WIDTH = 16,
  parameter int FRAC_BITS  = 8,
  parameter int CH         = 3,
  parameter int IMG_SIZE   = 416
) (
  input  logic                 Clk,
  input  logic                 Rst,
  conv_featuremap_par_if.slave bus,
  output logic                 dbg_state
);
  localparam int NTAP   = 9 * CH;
  localparam int WC_W   = $clog2(NTAP + 1);
  localparam int CNT_W  = (IMG_SIZE > 2) ? $clog2(IMG_SIZE) : 1;
  localparam int PROD_W = 2 * DATA_WIDTH;
  localparam int ACC_W  = PROD_W + $clog2(NTAP + 1);

  localparam logic [CNT_W-1:0]        LAST_IDX = CNT_W'(IMG_SIZE - 1);
  localparam logic [CNT_W-1:0]        TWO      = CNT_W'(2);
  localparam logic signed [ACC_W-1:0] SAT_MAX  = {{(ACC_W-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN  = {{(ACC_W-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

  typedef enum logic {ST_LOAD = 1'b0, ST_RUN = 1'b1} state_t;

  state_t          state, state_nx;
  logic [WC_W-1:0] wcnt, wcnt_nx;
  logic            coef_we, bias_we;
  logic            pix_acc;

  logic [CNT_W-1:0] row, col;
  logic             win_ok, win_last;

  logic signed [DATA_WIDTH-1:0] coef [NTAP];
  logic signed [DATA_WIDTH-1:0] bias_q;
  logic signed [DATA_WIDTH-1:0] lb0  [CH][IMG_SIZE];
  logic signed [DATA_WIDTH-1:0] lb1  [CH][IMG_SIZE];
  logic signed [DATA_WIDTH-1:0] win  [CH][3][3];
  logic signed [DATA_WIDTH-1:0] nwin [CH][3][3];
  logic signed [DATA_WIDTH-1:0] pix  [CH];

  logic signed [PROD_W-1:0]     prod_q [NTAP];
  logic                         v1, last1;

  logic signed [ACC_W-1:0]      acc, shr, act;
  logic signed [DATA_WIDTH-1:0] res;

  logic                  vout, fdone;
  logic [DATA_WIDTH-1:0] dout;

  // Next-state: cfg_start always wins and restarts the coefficient word counter.
  always_comb begin
    state_nx = state;
    wcnt_nx  = wcnt;
    coef_we  = 1'b0;
    bias_we  = 1'b0;
    if (bus.cfg_start) begin
      state_nx = ST_LOAD;
      wcnt_nx  = '0;
    end else if (state == ST_LOAD && bus.cfg_valid) begin
      if (wcnt == WC_W'(NTAP)) begin
        bias_we  = 1'b1;
        state_nx = ST_RUN;
        wcnt_nx  = '0;
      end else begin
        coef_we = 1'b1;
        wcnt_nx = wcnt + 1'b1;
      end
    end
  end

  assign pix_acc  = (state == ST_RUN) && bus.valid_in && !bus.cfg_start;
  assign win_ok   = (row >= TWO) && (col >= TWO);
  assign win_last = pix_acc && win_ok && (row == LAST_IDX) && (col == LAST_IDX);

  // Window as it will look after the incoming pixel shifts in; products are taken from this directly.
  always_comb begin
    for (int k = 0; k < CH; k++) begin
      pix[k] = bus.data_in[k*DATA_WIDTH +: DATA_WIDTH];
      for (int i = 0; i < 3; i++) begin
        for (int j = 0; j < 2; j++) begin
          nwin[k][i][j] = win[k][i][j+1];
        end
      end
      nwin[k][0][2] = lb1[k][col];
      nwin[k][1][2] = lb0[k][col];
      nwin[k][2][2] = pix[k];
    end
  end

  always_ff @(posedge Clk) begin
    if (coef_we) coef[wcnt] <= bus.cfg_data;
    if (bias_we) bias_q     <= bus.cfg_data;
    if (pix_acc) begin
      for (int k = 0; k < CH; k++) begin
        lb1[k][col] <= lb0[k][col];
        lb0[k][col] <= pix[k];
        for (int i = 0; i < 3; i++) begin
          for (int j = 0; j < 3; j++) begin
            win[k][i][j]            <= nwin[k][i][j];
            prod_q[9*k + 3*i + j]   <= nwin[k][i][j] * coef[9*k + 3*i + j];
          end
        end
      end
    end
  end

  // Sum stage: bias is aligned to the product scale (2*FRAC_BITS) before accumulation.
  always_comb begin
    acc = {{(ACC_W-DATA_WIDTH){bias_q[DATA_WIDTH-1]}}, bias_q};
    acc = acc <<< FRAC_BITS;
    for (int t = 0; t < NTAP; t++) begin
      acc = acc + {{(ACC_W-PROD_W){prod_q[t][PROD_W-1]}}, prod_q[t]};
    end
    shr = acc >>> FRAC_BITS;
    act = shr;
`ifdef CONV_FEATUREMAP_LEAKY_EN
    if (shr[ACC_W-1]) act = shr >>> 3;
`else
    act = shr;
`endif
    if (act > SAT_MAX)      res = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    else if (act < SAT_MIN) res = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    else                    res = act[DATA_WIDTH-1:0];
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state <= ST_LOAD;
      wcnt  <= '0;
      row   <= '0;
      col   <= '0;
      v1    <= 1'b0;
      last1 <= 1'b0;
      vout  <= 1'b0;
      fdone <= 1'b0;
      dout  <= '0;
    end else begin
      state <= state_nx;
      wcnt  <= wcnt_nx;
      if (bus.cfg_start) begin
        row   <= '0;
        col   <= '0;
        v1    <= 1'b0;
        last1 <= 1'b0;
        vout  <= 1'b0;
        fdone <= 1'b0;
      end else begin
        if (pix_acc) begin
          if (col == LAST_IDX) begin
            col <= '0;
            row <= (row == LAST_IDX) ? '0 : row + 1'b1;
          end else begin
            col <= col + 1'b1;
          end
        end
        v1    <= pix_acc && win_ok;
        last1 <= win_last;
        vout  <= v1;
        fdone <= v1 && last1;
        if (v1) dout <= res;
      end
    end
  end

  assign bus.data_out   = dout;
  assign bus.valid_out  = vout;
  assign bus.frame_done = fdone;
  assign bus.ready      = (state == ST_RUN);
  assign dbg_state      = (state == ST_RUN);
endmodule
